// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan display.
//   SEG_BLANK   - active-low segment pattern with every segment (and dp) off.
//   AN_ALL_OFF  - active-low digit enables with every digit off.
//   HEX7_CODE   - active-low a..g codes for hex digits 0..F (bit 0 = a).
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] AN_ALL_OFF = 8'hFF;

  localparam logic [6:0] HEX7_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: bundle between the debug-word source and the display
// stage.
//   data_in[31:0]  word to display (digit k shows data_in[4k+3:4k])
//   load           capture data_in into the pending register
//   dp_mask[7:0]   per-digit decimal point, 1 = lit (live, not shadowed)
//   AN[7:0]        digit enables, active-low, one-hot-low
//   Seg[7:0]       segments, active-low; Seg[0]=a .. Seg[6]=g, Seg[7]=dp
//   frame_start    one-cycle pulse when digit 0 becomes active
// Modports: master = upstream source, slave = display stage.
interface seg7_scan_display_if;

  logic [31:0] data_in;
  logic        load;
  logic [7:0]  dp_mask;
  logic [7:0]  AN;
  logic [7:0]  Seg;
  logic        frame_start;

  modport master (output data_in, load, dp_mask,
                  input  AN, Seg, frame_start);

  modport slave  (input  data_in, load, dp_mask,
                  output AN, Seg, frame_start);

endinterface

// File: rtl/seg7_scan_display_hex7seg_decode.sv
// hex7seg_decode: combinational hex-nibble to seven-segment decoder.
//   nibble[3:0]  hex digit
//   seg[6:0]     active-low segments, seg[0]=a .. seg[6]=g
module hex7seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX7_CODE[nibble];
  end

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed driver for an 8-digit common-anode
// seven-segment display. One hex nibble of the shown word is driven per digit
// slot of SCAN_DIV clocks. New words go to a pending register and are copied
// to the shown register only at the frame boundary, so a frame never tears.
//   clk   rising-edge clock
//   rst_  synchronous active-low reset
//   bus   seg7_scan_display_if.slave (data_in, load, dp_mask -> AN, Seg,
//         frame_start)
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading-zero digits
// (digit 0 always shown).
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned DIV_W    = 17
) (
  input  logic                 clk,
  input  logic                 rst_,
  seg7_scan_display_if.slave   bus
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      pend_q, pend_d;
  logic [31:0]      shown_q, shown_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             fs_q, fs_d;

  logic             tick;
  logic             boundary;
  logic [3:0]       nibble;
  logic [6:0]       seg7;
  logic             blank;

  always_comb begin
    tick     = (div_q == DIV_W'(SCAN_DIV - 1));
    boundary = tick && (idx_q == 3'd7);

    div_d  = tick ? '0 : div_q + 1'b1;
    idx_d  = tick ? idx_q + 3'd1 : idx_q;
    pend_d = bus.load ? bus.data_in : pend_q;

    // A load on the boundary cycle bypasses pend so it shows immediately.
    shown_d = shown_q;
    if (boundary) begin
      shown_d = bus.load ? bus.data_in : pend_q;
    end

    fs_d = boundary;
  end

  // Outputs are built from the next-state idx/shown so AN/Seg move on the
  // same edge as idx.
  always_comb begin
    nibble = shown_d[{idx_d, 2'b00} +: 4];
  end

  hex7seg_decode u_decode (
    .nibble (nibble),
    .seg    (seg7)
  );

  always_comb begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank = (idx_d != 3'd0) && ((shown_d >> {idx_d, 2'b00}) == 32'd0);
`else
    blank = 1'b0;
`endif
    an_d = ~(8'd1 << idx_d);
    seg_d = blank ? SEG_BLANK : {~bus.dp_mask[idx_d], seg7};
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      div_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      shown_q <= '0;
      an_q    <= AN_ALL_OFF;
      seg_q   <= SEG_BLANK;
      fs_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      shown_q <= shown_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.AN          = an_q;
  assign bus.Seg         = seg_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed self-checking bench for seg7_scan_display
// with SCAN_DIV=4. Outputs are sampled 1 time unit after each rising edge.
module tb_seg7_scan_display;

  logic clk;
  logic rst_;
  int   n_checks;
  int   n_errors;

  seg7_scan_display_if bus ();

  seg7_scan_display #(
    .SCAN_DIV (4),
    .DIV_W    (2)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (bus.frame_start !== 1'b1 && n < 40);
    chk(tag, {31'd0, bus.frame_start}, 32'd1);
  endtask

  logic [7:0] old_seg [8];
  logic [7:0] lz_seg  [8];

  initial begin
    old_seg = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lz_seg  = '{8'hC0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
    lz_seg  = '{8'hC0, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
    n_checks = 0;
    n_errors = 0;
    rst_ = 1'b0;
    bus.data_in = '0;
    bus.load    = 1'b0;
    bus.dp_mask = '0;

    // Reset
    step(3);
    chk("rst_an", {24'd0, bus.AN}, 32'hFF);
    chk("rst_seg", {24'd0, bus.Seg}, 32'hFF);
    chk("rst_fs", {31'd0, bus.frame_start}, 32'd0);
    rst_ = 1'b1;
    step(1);
    chk("first_an", {24'd0, bus.AN}, 32'hFE);
    chk("first_seg", {24'd0, bus.Seg}, 32'hC0);

    // Scan order
    bus.data_in = 32'h89ABCDEF;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    wait_frame("scan_fs0");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("scan_an%0d", k), {24'd0, bus.AN}, {24'd0, ~(8'd1 << k)});
      chk($sformatf("scan_seg%0d", k), {24'd0, bus.Seg}, {24'd0, old_seg[k]});
      step(1);
      chk($sformatf("scan_fslo%0d", k), {31'd0, bus.frame_start}, 32'd0);
      step(3);
    end
    chk("scan_fs_period", {31'd0, bus.frame_start}, 32'd1);

    // Tear-free: load mid-frame at idx 3
    step(12);
    chk("tear_an3", {24'd0, bus.AN}, 32'hF7);
    bus.data_in = 32'h11111111;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    chk("tear_seg3", {24'd0, bus.Seg}, {24'd0, old_seg[3]});
    step(3);
    for (int k = 4; k < 8; k++) begin
      chk($sformatf("tear_old%0d", k), {24'd0, bus.Seg}, {24'd0, old_seg[k]});
      step(4);
    end
    chk("tear_fs", {31'd0, bus.frame_start}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("tear_new%0d", k), {24'd0, bus.Seg}, 32'hF9);
      step(4);
    end

    // Simultaneous load on the boundary tick
    step(31);
    bus.data_in = 32'h00000007;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    chk("bypass_fs", {31'd0, bus.frame_start}, 32'd1);
    chk("bypass_an", {24'd0, bus.AN}, 32'hFE);
    chk("bypass_seg", {24'd0, bus.Seg}, 32'hF8);
    step(4);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk("bypass_seg1", {24'd0, bus.Seg}, 32'hFF);
`else
    chk("bypass_seg1", {24'd0, bus.Seg}, 32'hC0);
`endif

    // Decimal point on digit 0 only
    bus.dp_mask = 8'h01;
    wait_frame("dp_fs");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("dp_bit%0d", k), {31'd0, bus.Seg[7]},
          (k == 0) ? 32'd0 : 32'd1);
      step(4);
    end

    // Mid-frame reset at idx 5
    step(20);
    chk("mrst_an5", {24'd0, bus.AN}, 32'hDF);
    rst_ = 1'b0;
    step(1);
    chk("mrst_an", {24'd0, bus.AN}, 32'hFF);
    chk("mrst_seg", {24'd0, bus.Seg}, 32'hFF);
    chk("mrst_fs", {31'd0, bus.frame_start}, 32'd0);
    rst_ = 1'b1;
    step(1);
    chk("mrst_restart_an", {24'd0, bus.AN}, 32'hFE);
    chk("mrst_restart_seg", {24'd0, bus.Seg}, 32'h40);
    bus.dp_mask = 8'h00;

    // Leading zeros
    bus.data_in = 32'h00000120;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    wait_frame("lz_fs");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("lz_an%0d", k), {24'd0, bus.AN}, {24'd0, ~(8'd1 << k)});
      chk($sformatf("lz_seg%0d", k), {24'd0, bus.Seg}, {24'd0, lz_seg[k]});
      step(4);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream display stage of the multi-cycle CPU top.
- Consumes a 32-bit debug word (PC, IR, ALU F or MDR, chosen upstream by the switch mux) and drives the board's 8-digit common-anode seven-segment display on AN/Seg.
- Time-multiplexes one hex nibble per digit, with tear-free frame-boundary updates.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz); legal range is 2 or more.
- DIV_W, 17: prescaler counter width; must satisfy 2^DIV_W >= SCAN_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- data_in  in  32  word to display; digit k shows data_in[4k+3:4k].
- load  in  1  capture data_in into the pending register this cycle.
- dp_mask  in  8  per-digit decimal point, 1 = lit; sampled live and not shadowed.
- AN  out  8  digit enables, active-low, one-hot-low.
- Seg  out  8  segments, active-low; Seg[0]=a … Seg[6]=g, Seg[7]=dp.
- frame_start  out  1  one-cycle pulse when digit 0 becomes active.

Behaviour:
- One clock domain. Reset is synchronous, active-low, on rst_.
- Reset values:
  - AN=8'hFF, Seg=8'hFF, frame_start=0.
  - Internal registers: prescaler=0, idx=0, pend=0, shown=0.
  - Reset mid-frame blanks the display on the next edge.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - tick = (prescaler == SCAN_DIV-1).
- Digit index idx (3 bits):
  - Increments on tick; wraps 7 to 0.
  - frame boundary = tick && idx==7.
- Load path:
  - load=1 sets pend <= data_in on that edge.
  - Multiple loads within one frame: only the last is kept.
- Shown update, at the frame boundary only:
  - shown <= load ? data_in : pend. A same-cycle load bypasses pend into shown.
  - pend is also written in that case.
- Outputs are registered, computed from the next idx and next shown:
  - AN: bit idx low, all others high. Never more than one bit low.
  - Seg[6:0] = hex decode of shown nibble idx. Codes with dp off: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.
  - Seg[7] = ~dp_mask[idx].
- Latency:
  - AN/Seg change on the same edge that idx changes.
  - First digit is active on the first edge after rst_ deasserts: AN=FE, showing shown nibble 0 (zero after reset).
- frame_start is 1 for exactly one cycle, on the edge where idx wraps 7 to 0.
- A load value becomes visible at the next frame boundary, at most 8*SCAN_DIV cycles later.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit k is blanked (Seg=8'hFF; AN still scans) when shown[31:4k] == 0 and k != 0.
  - Digit 0 is always shown.
  - The dp bit is forced off on blanked digits.
- Undefined: all 8 digits always display, including leading zeros.

Decomposition:
- Shared package seg7_pkg:
  - Active-low segment constants SEG_BLANK=8'hFF.
  - The 16-entry hex code table.
  - AN_ALL_OFF=8'hFF.
- One combinational sub-module, hex7seg_decode (4-bit nibble in, 7-bit active-low segments out), instantiated once on the muxed nibble.
- Prescaler, idx and the shadow registers stay in the top block.

Test Plan (SCAN_DIV=4):
- Reset: hold rst_=0 for 3 cycles → AN=FF, Seg=FF, frame_start=0. First edge after release → AN=FE, Seg=C0.
- Scan order: load 32'h89ABCDEF, wait for frame_start → successive slots show AN FE/FD/…/7F with Seg 8E, 86, A1, C6, 83, 88, 90, 80. Each slot lasts 4 cycles; frame_start repeats every 32 cycles.
- Tear-free update: load 32'h11111111 at idx=3 mid-frame → digits 3..7 of that frame still show the old value; the next frame shows all F9.
- Simultaneous load at the frame boundary: load 32'h00000007 on the tick with idx=7 → the very next slot (AN=FE) shows Seg=F8.
- DP and mid-frame reset: dp_mask=8'h01 → Seg[7]=0 only while AN=FE. Assert rst_=0 at idx=5 → AN=FF on the next edge, and scan restarts at idx 0.
- Feature: with SEG7_LEADING_ZERO_BLANK_EN, load 32'h00000120 → digits 3..7 give Seg=FF and digits 0..2 give C0/A4/F9. Without the macro, digits 3..7 give C0.
